// File: rtl/elp_distributor.sv
// Routes each ELP result from the shared key-equation solver to the owning
// channel's Chien search through a per-channel 2-entry show-ahead buffer.
module elp_distributor #(
    parameter int Channel           = 4,
    parameter int GaloisFieldDegree = 12,
    parameter int ELPCoefficients   = 15
) (
    input  logic                                             iClock,
    input  logic                                             iReset,
    input  logic                                             iKESDone,
    input  logic [Channel-1:0]                               iChannelSel,
    input  logic                                             iChunkNumber,
    input  logic                                             iDataForwarding,
    input  logic                                             iLastChunk,
    input  logic [4:0]                                       iELPDegree,
    input  logic [GaloisFieldDegree*ELPCoefficients-1:0]     iELPCoefficients,
    output logic [Channel-1:0]                               oChannelFull,
    output logic [Channel-1:0]                               oELPValid,
    input  logic [Channel-1:0]                               iCSReady,
    output logic [Channel*5-1:0]                             oELPDegree,
    output logic [Channel*GaloisFieldDegree*ELPCoefficients-1:0] oELPCoefficients,
    output logic [Channel-1:0]                               oChunkNumber,
    output logic [Channel-1:0]                               oDataForwarding,
    output logic [Channel-1:0]                               oLastChunk,
    output logic [Channel-1:0]                               oPageDone,
    output logic [1:0]                                       oError
);

    localparam int CoefWidth  = GaloisFieldDegree * ELPCoefficients;
    localparam int EntryWidth = CoefWidth + 8;

    // Entry layout: {coefficients, degree[4:0], chunk, forwarding, last}
    function automatic logic isOneHot(input logic [Channel-1:0] sel);
        logic [Channel-1:0] one;
        one = {{(Channel-1){1'b0}}, 1'b1};
        return (sel != {Channel{1'b0}}) && ((sel & (sel - one)) == {Channel{1'b0}});
    endfunction

    logic [EntryWidth-1:0] mem_r   [Channel][2];
    logic [1:0]            count_r [Channel];
    logic [Channel-1:0]    wrPtr_r;
    logic [Channel-1:0]    rdPtr_r;

    logic [1:0]            count_s [Channel];
    logic [EntryWidth-1:0] head_s  [Channel];
    logic [Channel-1:0]    wrPtr_s;
    logic [Channel-1:0]    rdPtr_s;
    logic [Channel-1:0]    push_s;
    logic [Channel-1:0]    pop_s;
    logic [Channel-1:0]    overflow_s;
    logic                  selValid_s;
    logic                  invalidSel_s;
    logic [EntryWidth-1:0] entry_s;

    // Next-state for every channel buffer; the head is forwarded from the
    // incoming entry when the write lands on the slot about to become head.
    always_comb begin
        selValid_s   = isOneHot(iChannelSel);
        invalidSel_s = iKESDone & ~selValid_s;
        entry_s      = {iELPCoefficients, iELPDegree, iChunkNumber, iDataForwarding, iLastChunk};
        for (int c = 0; c < Channel; c++) begin
            overflow_s[c] = iKESDone & selValid_s & iChannelSel[c] & (count_r[c] == 2'd2);
            push_s[c]     = iKESDone & selValid_s & iChannelSel[c] & (count_r[c] != 2'd2);
            pop_s[c]      = oELPValid[c] & iCSReady[c];
            wrPtr_s[c]    = wrPtr_r[c] ^ push_s[c];
            rdPtr_s[c]    = rdPtr_r[c] ^ pop_s[c];
            count_s[c]    = count_r[c] + {1'b0, push_s[c]} - {1'b0, pop_s[c]};
            if (push_s[c] && (wrPtr_r[c] == rdPtr_s[c])) begin
                head_s[c] = entry_s;
            end else begin
                head_s[c] = mem_r[c][rdPtr_s[c]];
            end
        end
    end

    // Buffer storage, pointers and all registered outputs.
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            for (int c = 0; c < Channel; c++) begin
                mem_r[c][0] <= {EntryWidth{1'b0}};
                mem_r[c][1] <= {EntryWidth{1'b0}};
                count_r[c]  <= 2'd0;
            end
            wrPtr_r          <= {Channel{1'b0}};
            rdPtr_r          <= {Channel{1'b0}};
            oChannelFull     <= {Channel{1'b0}};
            oELPValid        <= {Channel{1'b0}};
            oELPDegree       <= {(Channel*5){1'b0}};
            oELPCoefficients <= {(Channel*CoefWidth){1'b0}};
            oChunkNumber     <= {Channel{1'b0}};
            oDataForwarding  <= {Channel{1'b0}};
            oLastChunk       <= {Channel{1'b0}};
            oPageDone        <= {Channel{1'b0}};
            oError           <= 2'b00;
        end else begin
            for (int c = 0; c < Channel; c++) begin
                if (push_s[c]) begin
                    mem_r[c][wrPtr_r[c]] <= entry_s;
                end else begin
                    mem_r[c][wrPtr_r[c]] <= mem_r[c][wrPtr_r[c]];
                end
                count_r[c]                        <= count_s[c];
                oChannelFull[c]                   <= (count_s[c] == 2'd2);
                oELPValid[c]                      <= (count_s[c] != 2'd0);
                oELPDegree[c*5 +: 5]              <= head_s[c][7:3];
                oELPCoefficients[c*CoefWidth +: CoefWidth] <= head_s[c][EntryWidth-1:8];
                oChunkNumber[c]                   <= head_s[c][2];
                oDataForwarding[c]                <= head_s[c][1];
                oLastChunk[c]                     <= head_s[c][0];
                oPageDone[c]                      <= pop_s[c] & oLastChunk[c];
            end
            wrPtr_r <= wrPtr_s;
            rdPtr_r <= rdPtr_s;
            oError  <= oError | {invalidSel_s, |overflow_s};
        end
    end

endmodule

// File: tb/tb_elp_distributor.sv
// Directed bench for elp_distributor with a small reference-queue scoreboard
// for the interleaved two-channel traffic.
module tb_elp_distributor;

    localparam int CH = 4;
    localparam int CW = 180;

    logic              iClock;
    logic              iReset;
    logic              iKESDone;
    logic [CH-1:0]     iChannelSel;
    logic              iChunkNumber;
    logic              iDataForwarding;
    logic              iLastChunk;
    logic [4:0]        iELPDegree;
    logic [CW-1:0]     iELPCoefficients;
    logic [CH-1:0]     oChannelFull;
    logic [CH-1:0]     oELPValid;
    logic [CH-1:0]     iCSReady;
    logic [CH*5-1:0]   oELPDegree;
    logic [CH*CW-1:0]  oELPCoefficients;
    logic [CH-1:0]     oChunkNumber;
    logic [CH-1:0]     oDataForwarding;
    logic [CH-1:0]     oLastChunk;
    logic [CH-1:0]     oPageDone;
    logic [1:0]        oError;

    int checks   = 0;
    int failures = 0;

    logic [37:0] q0[$];
    logic [37:0] q1[$];

    elp_distributor dut (
        .iClock(iClock), .iReset(iReset), .iKESDone(iKESDone),
        .iChannelSel(iChannelSel), .iChunkNumber(iChunkNumber),
        .iDataForwarding(iDataForwarding), .iLastChunk(iLastChunk),
        .iELPDegree(iELPDegree), .iELPCoefficients(iELPCoefficients),
        .oChannelFull(oChannelFull), .oELPValid(oELPValid), .iCSReady(iCSReady),
        .oELPDegree(oELPDegree), .oELPCoefficients(oELPCoefficients),
        .oChunkNumber(oChunkNumber), .oDataForwarding(oDataForwarding),
        .oLastChunk(oLastChunk), .oPageDone(oPageDone), .oError(oError)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic strobe(input logic [3:0] sel, input logic chunk, input logic fwd,
                          input logic last, input logic [4:0] deg, input logic [31:0] coef);
        iKESDone         = 1'b1;
        iChannelSel      = sel;
        iChunkNumber     = chunk;
        iDataForwarding  = fwd;
        iLastChunk       = last;
        iELPDegree       = deg;
        iELPCoefficients = '0;
        iELPCoefficients[31:0] = coef;
    endtask

    task automatic idle();
        iKESDone    = 1'b0;
        iChannelSel = 4'b0000;
        iLastChunk  = 1'b0;
    endtask

    task automatic checkHead(input int ch, input logic [37:0] e, input string tag);
        logic [CW-1:0] expCoef;
        expCoef = '0;
        expCoef[31:0] = e[31:0];
        check({tag, "_deg"}, oELPDegree[ch*5 +: 5], e[36:32]);
        check({tag, "_coef"}, oELPCoefficients[ch*CW +: CW], expCoef);
        check({tag, "_fwd"}, oDataForwarding[ch], e[37]);
    endtask

    initial begin
        logic [1:0]  rdy;
        logic [37:0] e;
        logic [31:0] c32;
        logic        fwd;
        int          ch;
        int          serial;

        // Reset hold with a strobe asserted
        iReset = 1'b0;
        iCSReady = 4'b0000;
        iDataForwarding = 1'b0;
        strobe(4'b0001, 1'b0, 1'b0, 1'b1, 5'd7, 32'hABCD);
        repeat (3) tick();
        check("rst_valid", oELPValid, 4'b0000);
        check("rst_full", oChannelFull, 4'b0000);
        check("rst_error", oError, 2'b00);
        check("rst_pagedone", oPageDone, 4'b0000);
        check("rst_degree", oELPDegree, 20'h0);
        check("rst_coef", oELPCoefficients, '0);
        check("rst_last", oLastChunk, 4'b0000);
        iReset = 1'b1;
        idle();
        tick();
        check("post_rst_valid", oELPValid, 4'b0000);

        // Single route to channel 2
        iCSReady = 4'b0100;
        strobe(4'b0100, 1'b0, 1'b0, 1'b0, 5'd3, 32'h001);
        tick();
        idle();
        check("route_valid", oELPValid, 4'b0100);
        check("route_deg", oELPDegree[2*5 +: 5], 5'd3);
        check("route_coef", oELPCoefficients[2*CW +: CW], 180'h1);
        tick();
        check("route_popped", oELPValid, 4'b0000);
        check("route_nopage", oPageDone, 4'b0000);

        // Fill and overflow on channel 0
        iCSReady = 4'b0000;
        strobe(4'b0001, 1'b0, 1'b0, 1'b0, 5'd1, 32'h11);
        tick();
        check("fill1_full", oChannelFull, 4'b0000);
        check("fill1_valid", oELPValid, 4'b0001);
        strobe(4'b0001, 1'b1, 1'b0, 1'b0, 5'd2, 32'h22);
        tick();
        check("fill2_full", oChannelFull, 4'b0001);
        strobe(4'b0001, 1'b0, 1'b0, 1'b0, 5'd5, 32'h33);
        tick();
        idle();
        check("ovf_error", oError, 2'b01);
        check("ovf_full", oChannelFull, 4'b0001);
        check("ovf_head_chunk", oChunkNumber[0], 1'b0);
        check("ovf_head_deg", oELPDegree[4:0], 5'd1);
        tick();
        check("stall_head_deg", oELPDegree[4:0], 5'd1);
        iCSReady = 4'b0001;
        tick();
        check("pop1_chunk", oChunkNumber[0], 1'b1);
        check("pop1_deg", oELPDegree[4:0], 5'd2);
        check("pop1_coef", oELPCoefficients[CW-1:0], 180'h22);
        check("pop1_full", oChannelFull, 4'b0000);
        check("pop1_valid", oELPValid, 4'b0001);
        tick();
        check("pop2_valid", oELPValid, 4'b0000);
        iCSReady = 4'b0000;

        // Page done on channel 3
        strobe(4'b1000, 1'b1, 1'b0, 1'b1, 5'd4, 32'h44);
        tick();
        idle();
        check("page_valid", oELPValid, 4'b1000);
        check("page_last", oLastChunk[3], 1'b1);
        check("page_before", oPageDone, 4'b0000);
        iCSReady = 4'b1000;
        tick();
        check("page_pulse", oPageDone, 4'b1000);
        check("page_empty", oELPValid, 4'b0000);
        iCSReady = 4'b0000;
        tick();
        check("page_pulse_end", oPageDone, 4'b0000);

        // Invalid selects
        strobe(4'b0011, 1'b0, 1'b0, 1'b0, 5'd6, 32'h55);
        tick();
        check("inv_multi_valid", oELPValid, 4'b0000);
        check("inv_multi_err", oError, 2'b11);
        strobe(4'b0000, 1'b0, 1'b0, 1'b0, 5'd6, 32'h66);
        tick();
        idle();
        check("inv_zero_valid", oELPValid, 4'b0000);
        tick();
        check("inv_sticky", oError, 2'b11);

        // Interleaved channels 0/1 with random ready, scoreboarded
        serial = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            rdy = 2'($urandom_range(0, 3));
            iCSReady = {2'b00, rdy};
            for (int k = 0; k < 2; k++) begin
                if (oELPValid[k] && iCSReady[k]) begin
                    if (k == 0) begin
                        check("sb_q0_nonempty", q0.size() != 0, 1'b1);
                        if (q0.size() != 0) begin
                            e = q0.pop_front();
                            checkHead(0, e, "sb_ch0");
                        end
                    end else begin
                        check("sb_q1_nonempty", q1.size() != 0, 1'b1);
                        if (q1.size() != 0) begin
                            e = q1.pop_front();
                            checkHead(1, e, "sb_ch1");
                        end
                    end
                end
            end
            ch = int'($urandom_range(0, 1));
            if (!oChannelFull[ch] && ($urandom_range(0, 2) != 0)) begin
                c32 = $urandom;
                fwd = 1'($urandom_range(0, 1));
                serial++;
                strobe((ch == 0) ? 4'b0001 : 4'b0010, 1'b0, fwd, 1'b0, 5'(serial), c32);
                e = {fwd, 5'(serial), c32};
                if (ch == 0) q0.push_back(e);
                else q1.push_back(e);
            end else begin
                idle();
            end
            tick();
        end
        idle();
        iCSReady = 4'b0011;
        for (int cyc = 0; cyc < 6; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (oELPValid[k]) begin
                    if (k == 0) begin
                        check("drain_q0_nonempty", q0.size() != 0, 1'b1);
                        if (q0.size() != 0) begin
                            e = q0.pop_front();
                            checkHead(0, e, "drain_ch0");
                        end
                    end else begin
                        check("drain_q1_nonempty", q1.size() != 0, 1'b1);
                        if (q1.size() != 0) begin
                            e = q1.pop_front();
                            checkHead(1, e, "drain_ch1");
                        end
                    end
                end
            end
            tick();
        end
        check("drain_q0_empty", q0.size(), 0);
        check("drain_q1_empty", q1.size(), 0);
        check("drain_valid", oELPValid, 4'b0000);
        check("sb_error", oError, 2'b11);
        check("sb_count", serial != 0, 1'b1);

        // Reset mid-operation discards the buffered entry with no page pulse
        iCSReady = 4'b0000;
        strobe(4'b0010, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99);
        tick();
        idle();
        check("midrst_valid_pre", oELPValid, 4'b0010);
        iReset = 1'b0;
        iCSReady = 4'b0010;
        tick();
        check("midrst_valid", oELPValid, 4'b0000);
        check("midrst_page", oPageDone, 4'b0000);
        check("midrst_error", oError, 2'b00);
        iReset = 1'b1;
        tick();
        check("midrst_page_after", oPageDone, 4'b0000);
        check("midrst_valid_after", oELPValid, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elp_distributor.md
# elp_distributor

Return path of the shared key-equation solver (KES): accepts each error-locator polynomial (ELP) result produced by the single shared KES and routes it to the per-channel Chien search unit of the channel that owned the syndromes. Each channel gets a 2-entry show-ahead buffer (one entry per chunk) with a valid/ready handshake. It sits between the shared KES output and the `Channel` page decoders. It is the counterpart of the inter-channel syndrome buffer, whose registered one-hot channel select tags each KES job.

## Interface
- Channel, 4, number of flash channels sharing the KES
- GaloisFieldDegree, 12, bits per GF element
- ELPCoefficients, 15, coefficients per ELP (t = 14, lambda0..lambda14)
- iClock  input  1  rising-edge clock
- iReset  input  1  synchronous, active-low reset (reset when 0 at posedge)
- iKESDone  input  1  one-cycle strobe: ELP result valid this cycle
- iChannelSel  input  4  one-hot owning channel of the result
- iChunkNumber  input  1  chunk index within page (0/1)
- iDataForwarding  input  1  chunk error-free, forward data unchanged
- iLastChunk  input  1  final chunk of the page for that channel
- iELPDegree  input  5  ELP degree (error count)
- iELPCoefficients  input  GaloisFieldDegree*ELPCoefficients  lambda0 in LSBs
- oChannelFull  output  Channel  per-channel buffer holds 2 entries (registered)
- oELPValid  output  Channel  head entry present
- iCSReady  input  Channel  Chien search accepts head entry
- oELPDegree  output  Channel*5  head degree, channel c at [5c+4:5c]
- oELPCoefficients  output  Channel*GaloisFieldDegree*ELPCoefficients  head coefficients, channel-sliced
- oChunkNumber, oDataForwarding, oLastChunk  output  Channel each  head flags
- oPageDone  output  Channel  one-cycle pulse when an entry with LastChunk set is popped
- oError  output  2  sticky: [0] overflow drop, [1] invalid select drop

## Operation
- Per channel: 2-entry circular buffer, 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- Write: on iKESDone with iChannelSel exactly one-hot, the selected channel with count < 2 stores {coefficients, degree, chunk, forwarding, last} at the write pointer. Write pointer increments and wraps 1 -> 0.
- Full drop: iKESDone to a channel with registered count == 2 is discarded and sets oError[0]. This applies even if that channel pops in the same cycle. Upstream uses oChannelFull to hold off.
- Invalid select: iKESDone with iChannelSel zero or multi-hot is discarded, no channel is written, and oError[1] is set.
- Read: oELPValid[c] = (count != 0). Head fields are driven from storage at the read pointer (show-ahead). Pop when oELPValid[c] & iCSReady[c]; read pointer increments.
- Simultaneous push and pop on a channel with count 1: both happen and count stays 1. On a channel with count 0, only the push is possible (valid is not yet asserted).
- oPageDone[c] is registered: it pulses the cycle after a pop whose head had LastChunk = 1.
- Channels are fully independent; a stall on one channel never blocks the others.
- oError bits clear only on reset.
- Reset: all counts and pointers 0, storage cleared to 0. Every output resets to 0, including all data fields, oChannelFull, oPageDone and oError. Reset mid-operation discards buffered entries with no oPageDone.

## Timing
- Latency: iKESDone at edge N into an empty channel gives oELPValid high after edge N, so data is usable in cycle N+1.
- Pop at edge M updates valid and head after edge M. Back-to-back pops run 1 per cycle.
- oChannelFull reflects the count after the current edge. There is no combinational path from iKESDone or iCSReady to oChannelFull or oELPValid.
- Head data is stable while oELPValid is high and iCSReady is low.
- One write per cycle maximum (single KES); reads on all channels proceed in parallel.

## Test plan
- Reset hold: iReset = 0 for 3 cycles with iKESDone = 1 -> all outputs 0, no entry written, oError = 0.
- Single route: iChannelSel = 4'b0100, degree 3, lambda0 = 12'h001, iCSReady[2] = 1 -> oELPValid = 4'b0100 for exactly 1 cycle in N+1, head degree 3; other channels stay idle.
- Fill and overflow: 3 strobes to channel 0 with iCSReady[0] = 0 (chunks 0, 1, 0) -> oChannelFull[0] = 1 after the 2nd; the 3rd is dropped and oError = 2'b01. Then raise ready -> pops chunk 0 then chunk 1, and the buffer empties.
- Page done: chunk 1 with iLastChunk = 1 to channel 3, popped at edge M -> oPageDone = 4'b1000 for one cycle after M.
- Invalid select: iChannelSel = 4'b0011 and then 4'b0000 with iKESDone -> no oELPValid change, oError[1] = 1 sticky.
- Concurrent channels: interleave writes to channels 0 and 1 with random iCSReady -> per-channel order preserved and no loss while the upstream respects oChannelFull. Scoreboard against a reference queue.
